// File: rtl/bram_line_reader.sv
// bram_line_reader
// Gathers a burst of 32-bit words from a native BRAM read port into one
// 32*MAX_WORDS-bit cache line. A rising edge on i_trigger starts a read. The
// block then issues one address per cycle. A latency pipeline tags every
// issued word with its slot index, so each returning word lands in the right
// place in o_rddata.
//
// Handshake: o_busy is high from the cycle after a start is accepted until
// the FSM is back in IDLE. o_end and o_valid pulse together for exactly one
// cycle when the line is complete. o_rddata then holds that line until the
// next start clears it. A trigger edge seen while busy is dropped, not queued.

module bram_line_reader #(
  parameter int READ_LATENCY = 2,   // BRAM address-to-data cycles, 1..4
  parameter int MAX_WORDS    = 16   // words per line, at most 31
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESETN,
  input  logic                    i_trigger,
  input  logic [14:0]             i_base_addr,
  input  logic [4:0]              i_word_count,
  output logic                    o_busy,
  output logic                    o_end,
  output logic                    o_valid,
  output logic [32*MAX_WORDS-1:0] o_rddata,
  output logic                    o_bram_en,
  output logic [3:0]              o_bram_we,
  output logic [14:0]             o_bram_addr,
  input  logic [31:0]             i_bram_rddata
);

  localparam int          LINE_W  = 32 * MAX_WORDS;
  localparam int          IDX_W   = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [4:0]  MAX_CNT = 5'(MAX_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // FSM and control
  state_t              state_q,     state_d;
  logic                trig1_q,     trig1_d;
  logic                trig2_q,     trig2_d;
  logic [14:0]         base_q,      base_d;
  logic [4:0]          num_q,       num_d;
  logic [4:0]          issue_cnt_q, issue_cnt_d;
  logic [4:0]          cap_cnt_q,   cap_cnt_d;

  // Registered outputs
  logic                busy_q,      busy_d;
  logic                end_q,       end_d;
  logic                valid_q,     valid_d;
  logic [LINE_W-1:0]   rddata_q,    rddata_d;
  logic                en_q,        en_d;
  logic [14:0]         addr_q,      addr_d;
  logic [IDX_W-1:0]    idx_q,       idx_d;

  // Latency pipeline: one {valid, slot index} entry per issued word
  logic                pipe_v_q   [READ_LATENCY];
  logic                pipe_v_d   [READ_LATENCY];
  logic [IDX_W-1:0]    pipe_idx_q [READ_LATENCY];
  logic [IDX_W-1:0]    pipe_idx_d [READ_LATENCY];

  logic                start;
  logic                tail_v;
  logic [IDX_W-1:0]    tail_idx;
  logic                capture_on;

  assign start      = trig1_q & ~trig2_q;
  assign tail_v     = pipe_v_q[READ_LATENCY-1];
  assign tail_idx   = pipe_idx_q[READ_LATENCY-1];
  assign capture_on = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);

  assign o_busy      = busy_q;
  assign o_end       = end_q;
  assign o_valid     = valid_q;
  assign o_rddata    = rddata_q;
  assign o_bram_en   = en_q;
  assign o_bram_addr = addr_q;
  assign o_bram_we   = 4'b0000;

  // Next-state logic: trigger edge detect, latency pipeline, capture, FSM
  always_comb begin
    state_d     = state_q;
    trig1_d     = i_trigger;
    trig2_d     = trig1_q;
    base_d      = base_q;
    num_d       = num_q;
    issue_cnt_d = issue_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    end_d       = 1'b0;
    valid_d     = 1'b0;
    rddata_d    = rddata_q;
    en_d        = 1'b0;
    addr_d      = addr_q;
    idx_d       = idx_q;

    // The pipeline is loaded from the registered enable, so its tail lines
    // up with the BRAM data exactly READ_LATENCY cycles after the address.
    pipe_v_d[0]   = en_q;
    pipe_idx_d[0] = idx_q;
    for (int k = 1; k < READ_LATENCY; k++) begin
      pipe_v_d[k]   = pipe_v_q[k-1];
      pipe_idx_d[k] = pipe_idx_q[k-1];
    end

    if (capture_on && tail_v) begin
      for (int k = 0; k < MAX_WORDS; k++) begin
        if (tail_idx == IDX_W'(k)) begin
          rddata_d[32*k +: 32] = i_bram_rddata;
        end
      end
      cap_cnt_d = cap_cnt_q + 5'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_ISSUE;
          base_d      = i_base_addr;
          num_d       = ((i_word_count == 5'd0) || (i_word_count > MAX_CNT)) ?
                        MAX_CNT : i_word_count;
          rddata_d    = '0;
          issue_cnt_d = 5'd0;
          cap_cnt_d   = 5'd0;
        end
      end
      ST_ISSUE: begin
        // The 15-bit add wraps modulo 2^15 by construction.
        en_d        = 1'b1;
        addr_d      = base_q + {8'd0, issue_cnt_q, 2'b00};
        idx_d       = issue_cnt_q[IDX_W-1:0];
        issue_cnt_d = issue_cnt_q + 5'd1;
        if (issue_cnt_q == num_q - 5'd1) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Looking at the post-capture count lets DONE start on the cycle
        // right after the last word lands.
        if (cap_cnt_d == num_q) begin
          state_d = ST_DONE;
          end_d   = 1'b1;
          valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_d = (state_d != ST_IDLE);

  // All state registers; a synchronous active-low reset returns everything
  // to idle and drops any partial line.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_q     <= ST_IDLE;
      trig1_q     <= 1'b0;
      trig2_q     <= 1'b0;
      base_q      <= '0;
      num_q       <= '0;
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      busy_q      <= 1'b0;
      end_q       <= 1'b0;
      valid_q     <= 1'b0;
      rddata_q    <= '0;
      en_q        <= 1'b0;
      addr_q      <= '0;
      idx_q       <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe_v_q[k]   <= 1'b0;
        pipe_idx_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      trig1_q     <= trig1_d;
      trig2_q     <= trig2_d;
      base_q      <= base_d;
      num_q       <= num_d;
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      busy_q      <= busy_d;
      end_q       <= end_d;
      valid_q     <= valid_d;
      rddata_q    <= rddata_d;
      en_q        <= en_d;
      addr_q      <= addr_d;
      idx_q       <= idx_d;
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe_v_q[k]   <= pipe_v_d[k];
        pipe_idx_q[k] <= pipe_idx_d[k];
      end
    end
  end

endmodule

// File: tb/tb_bram_line_reader.sv
// tb_bram_line_reader
// Three readers with READ_LATENCY 1, 2 and 4 share the same control inputs.
// Each reader is paired with a BRAM model that returns 0xA0000000 + address
// after its latency. A single negedge monitor records the issued addresses,
// the enable/end timing and the captured line. Those records are then checked
// against a reference model built from base, count and latency.

module tb_bram_line_reader;

  logic         clk = 1'b0;
  logic         rstn;
  logic         trig;
  logic [14:0]  base_in;
  logic [4:0]   cnt_in;

  logic         busy   [3];
  logic         ended  [3];
  logic         valid  [3];
  logic         en     [3];
  logic [3:0]   we     [3];
  logic [14:0]  addr   [3];
  logic [511:0] rdata  [3];
  logic [31:0]  brd    [3];

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / edge counter ----------------
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // ---------------- DUTs and BRAM models ----------------
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    logic [14:0] pipe_a [4];

    bram_line_reader #(.READ_LATENCY(L), .MAX_WORDS(16)) u_dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rstn),
      .i_trigger     (trig),
      .i_base_addr   (base_in),
      .i_word_count  (cnt_in),
      .o_busy        (busy[g]),
      .o_end         (ended[g]),
      .o_valid       (valid[g]),
      .o_rddata      (rdata[g]),
      .o_bram_en     (en[g]),
      .o_bram_we     (we[g]),
      .o_bram_addr   (addr[g]),
      .i_bram_rddata (brd[g])
    );

    always @(posedge clk) begin
      if (en[g]) pipe_a[0] <= addr[g];
      for (int k = 1; k < 4; k++) pipe_a[k] <= pipe_a[k-1];
    end
    assign brd[g] = 32'hA0000000 + {17'd0, pipe_a[L-1]};
  end

  // ---------------- monitor ----------------
  logic         mon_clr;
  int           trig_edge;
  int           en_n     [3];
  int           first_en [3];
  int           end_n    [3];
  int           end_edge [3];
  int           we_bad   [3];
  int           vmis     [3];
  logic [14:0]  en_addr  [3][64];
  logic [511:0] line     [3];

  always @(negedge clk) begin
    if (mon_clr) begin
      trig_edge <= -1;
      for (int g = 0; g < 3; g++) begin
        en_n[g] <= 0; first_en[g] <= -1; end_n[g] <= 0; end_edge[g] <= -1;
        we_bad[g] <= 0; vmis[g] <= 0; line[g] <= '0;
      end
    end else begin
      // trigger seen high here is sampled by the next rising edge
      if (trig && trig_edge < 0) trig_edge <= edge_n + 1;
      for (int g = 0; g < 3; g++) begin
        if (en[g]) begin
          if (en_n[g] == 0) first_en[g] <= edge_n;
          if (en_n[g] < 64) en_addr[g][en_n[g]] <= addr[g];
          en_n[g] <= en_n[g] + 1;
        end
        if (we[g] != 4'b0000) we_bad[g] <= we_bad[g] + 1;
        if (valid[g] != ended[g]) vmis[g] <= vmis[g] + 1;
        if (ended[g]) begin
          end_n[g]    <= end_n[g] + 1;
          end_edge[g] <= edge_n;
          line[g]     <= rdata[g];
        end
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 2 : 4);
  endfunction

  function automatic int model_n(input logic [4:0] c);
    return (c == 5'd0 || c > 5'd16) ? 16 : int'(c);
  endfunction

  function automatic logic [14:0] model_addr(input logic [14:0] b, input int k);
    return 15'((int'(b) + 4 * k) % 32768);
  endfunction

  function automatic logic [511:0] model_line(input logic [14:0] b, input int n);
    logic [511:0] r = '0;
    for (int k = 0; k < 16; k++)
      if (k < n) r[32*k +: 32] = 32'hA0000000 + {17'd0, model_addr(b, k)};
    return r;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_line(input string name, input logic [511:0] act,
                          input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_read(input logic [14:0] b, input int exp_n, input string tag);
    logic [511:0] exp_line;
    exp_line = model_line(b, exp_n);
    for (int g = 0; g < 3; g++) begin
      int    l;
      int    bad;
      string p;
      l   = lat_of(g);
      p   = $sformatf("%s L%0d", tag, l);
      bad = 0;
      for (int k = 0; k < exp_n && k < 64; k++)
        if (en_addr[g][k] !== model_addr(b, k)) bad++;
      chk({p, " en_count"},     en_n[g], exp_n);
      chk({p, " addr_errors"},  bad, 0);
      chk({p, " first_en_lat"}, first_en[g] - trig_edge, 2);
      chk({p, " end_count"},    end_n[g], 1);
      chk({p, " end_lat"},      end_edge[g] - first_en[g], exp_n + l);
      chk_line({p, " line_at_end"}, line[g], exp_line);
      chk_line({p, " line_held"},   rdata[g], exp_line);
      chk({p, " we_nonzero"},   we_bad[g], 0);
      chk({p, " valid_vs_end"}, vmis[g], 0);
      chk({p, " busy_after"},   busy[g], 0);
    end
  endtask

  // ---------------- driver ----------------
  task automatic clear_mon();
    @(posedge clk); #1 mon_clr = 1'b1;
    @(posedge clk); #1 mon_clr = 1'b0;
  endtask

  // One read with a fixed observation window. The trigger stays high for
  // 'hold' sampled edges. A nonzero 'retrig' pulses it again at that step.
  // Base/count are scrambled once the start has been latched.
  task automatic do_read(input logic [14:0] b, input logic [4:0] c,
                         input int exp_n, input int hold, input int retrig,
                         input string tag);
    clear_mon();
    base_in = b; cnt_in = c; trig = 1'b1;
    for (int i = 1; i <= hold + 45; i++) begin
      @(posedge clk); #1;
      if (i == hold) trig = 1'b0;
      if (retrig > 0 && i == retrig) trig = 1'b1;
      if (retrig > 0 && i == retrig + 1) trig = 1'b0;
      if (i >= 2) begin
        base_in = 15'($urandom);
        cnt_in  = 5'($urandom);
      end
    end
    check_read(b, exp_n, tag);
  endtask

  typedef struct {
    logic [14:0] base;
    logic [4:0]  count;
    int          exp_n;
  } vec_t;

  vec_t tbl [7];

  // ---------------- stimulus ----------------
  initial begin
    tbl[0] = '{base: 15'h0100, count: 5'd16, exp_n: 16};
    tbl[1] = '{base: 15'h0040, count: 5'd4,  exp_n: 4};
    tbl[2] = '{base: 15'h0000, count: 5'd0,  exp_n: 16};
    tbl[3] = '{base: 15'h1234, count: 5'd31, exp_n: 16};
    tbl[4] = '{base: 15'h7FF8, count: 5'd4,  exp_n: 4};
    tbl[5] = '{base: 15'h2000, count: 5'd1,  exp_n: 1};
    tbl[6] = '{base: 15'h0ABC, count: 5'd17, exp_n: 16};

    rstn = 1'b0; trig = 1'b0; base_in = '0; cnt_in = '0; mon_clr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("reset L%0d busy", lat_of(g)),  busy[g], 0);
      chk($sformatf("reset L%0d end", lat_of(g)),   ended[g], 0);
      chk($sformatf("reset L%0d valid", lat_of(g)), valid[g], 0);
      chk($sformatf("reset L%0d en", lat_of(g)),    en[g], 0);
      chk($sformatf("reset L%0d we", lat_of(g)),    we[g], 0);
      chk($sformatf("reset L%0d addr", lat_of(g)),  addr[g], 0);
      chk_line($sformatf("reset L%0d rddata", lat_of(g)), rdata[g], '0);
    end
    rstn = 1'b1;

    // directed table
    for (int t = 0; t < 7; t++)
      do_read(tbl[t].base, tbl[t].count, tbl[t].exp_n, 1 + (t % 3), 0,
              $sformatf("tbl%0d", t));

    // randomized reads
    for (int r = 0; r < 8; r++) begin
      logic [14:0] b;
      logic [4:0]  c;
      b = 15'($urandom);
      c = 5'($urandom_range(0, 31));
      do_read(b, c, model_n(c), $urandom_range(1, 3), 0, $sformatf("rnd%0d", r));
    end

    // retrigger while busy is dropped; a held trigger starts only one read
    do_read(15'h0300, 5'd16, 16, 1, 5, "retrig");
    do_read(15'h0400, 5'd8, 8, 40, 0, "held");

    // reset pulse during the 8th enable cycle
    clear_mon();
    base_in = 15'h0500; cnt_in = 5'd16; trig = 1'b1;
    @(posedge clk); #1 trig = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (en_n[0] == 8) break;
    end
    chk("rst reached_8th_en", en_n[0], 8);
    rstn = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst L%0d busy", lat_of(g)), busy[g], 0);
      chk($sformatf("rst L%0d en", lat_of(g)),   en[g], 0);
      chk($sformatf("rst L%0d end", lat_of(g)),  ended[g], 0);
      chk_line($sformatf("rst L%0d rddata", lat_of(g)), rdata[g], '0);
    end
    rstn = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst L%0d no_end", lat_of(g)),   end_n[g], 0);
      chk($sformatf("rst L%0d en_total", lat_of(g)), en_n[g], 8);
    end
    do_read(15'h0100, 5'd16, 16, 2, 0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
